// File: rtl/mul_div_issue_queue_pkg.sv
// Shared types for the mul/div issue queue.
// Execute bus, dispatch bundle and wakeup bus definitions.
package mul_div_issue_queue_pkg;

  localparam int MDQ_SLOTS = 4;

  typedef logic [31:0] uint32_t;
  typedef logic [5:0]  reg_addr_t;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU,
    OP_HILO
  } md_op_e;

  typedef struct packed {
    md_op_e    op;
    reg_addr_t dest;
    uint32_t   src1_value;
    uint32_t   src2_value;
  } issue_to_execute_bus_t;

  typedef struct packed {
    issue_to_execute_bus_t           inst1;
    issue_to_execute_bus_t           inst2;
    reg_addr_t [MDQ_SLOTS-1:0]       tag;
    logic      [MDQ_SLOTS-1:0]       rdy;
  } mdq_dispatch_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t tag;
    uint32_t   value;
  } wakeup_bus_t;

endpackage

// File: rtl/mdq_operand_slot.sv
// One captured operand: tag, ready bit and value.
// Snoops every wakeup port; lowest-index match wins.
module mdq_operand_slot
  import mul_div_issue_queue_pkg::*;
#(
  parameter int WAKE_PORTS = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         load,
  input  logic                         active,
  input  reg_addr_t                    load_tag,
  input  logic                         load_rdy,
  input  uint32_t                      load_value,
  input  wakeup_bus_t [WAKE_PORTS-1:0] wakeup,
  output logic                         ready,
  output uint32_t                      value
);

  reg_addr_t tag_q;
  reg_addr_t cmp_tag;
  logic      hit;
  uint32_t   hit_value;

  // A slot being written compares the incoming tag, not the stale one
  assign cmp_tag = load ? load_tag : tag_q;

  always_comb begin
    hit       = 1'b0;
    hit_value = '0;
    for (int p = WAKE_PORTS - 1; p >= 0; p--) begin
      if (wakeup[p].valid && wakeup[p].tag == cmp_tag) begin
        hit       = 1'b1;
        hit_value = wakeup[p].value;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_q <= '0;
      ready <= 1'b0;
      value <= '0;
    end else if (flush) begin
      ready <= 1'b0;
    end else if (load) begin
      tag_q <= load_tag;
      if (load_rdy) begin
        ready <= 1'b1;
        value <= load_value;
      end else if (hit) begin
        ready <= 1'b1;
        value <= hit_value;
      end else begin
        ready <= 1'b0;
      end
    end else if (active && !ready && hit) begin
      ready <= 1'b1;
      value <= hit_value;
    end
  end

endmodule

// File: rtl/mul_div_issue_queue.sv
// In-order data-capture issue queue feeding the mul/div unit.
// Head pair issues once all four captured operands are ready.
module mul_div_issue_queue
  import mul_div_issue_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int WAKE_PORTS = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         dispatch_valid,
  output logic                         dispatch_allowin,
  input  mdq_dispatch_t                dispatch_pair,
  input  wakeup_bus_t [WAKE_PORTS-1:0] wakeup,
  output logic                         issue_to_mul_div_valid,
  input  logic                         mul_div_allowin,
  output issue_to_execute_bus_t        issue_inst1,
  output issue_to_execute_bus_t        issue_inst2,
  output logic [$clog2(DEPTH):0]       mdq_count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]   head_q;
  logic [PW:0]   tail_q;
  logic [PW-1:0] head_idx;
  logic [PW-1:0] tail_idx;
  logic          full;
  logic          fire_d;
  logic          fire_i;
  logic          head_rdy;

  logic [DEPTH-1:0] valid_q;
  md_op_e           op1_q   [DEPTH];
  md_op_e           op2_q   [DEPTH];
  reg_addr_t        dest1_q [DEPTH];
  reg_addr_t        dest2_q [DEPTH];
  logic             slot_rdy [DEPTH][MDQ_SLOTS];
  uint32_t          slot_val [DEPTH][MDQ_SLOTS];
  uint32_t          disp_val [MDQ_SLOTS];

  assign head_idx = head_q[PW-1:0];
  assign tail_idx = tail_q[PW-1:0];
  assign full     = (head_idx == tail_idx)
                 && (head_q[PW] != tail_q[PW]);
  assign mdq_count = tail_q - head_q;

  assign dispatch_allowin = !full;
  assign fire_d = dispatch_valid && dispatch_allowin;
  assign fire_i = issue_to_mul_div_valid && mul_div_allowin;

  assign disp_val[0] = dispatch_pair.inst1.src1_value;
  assign disp_val[1] = dispatch_pair.inst1.src2_value;
  assign disp_val[2] = dispatch_pair.inst2.src1_value;
  assign disp_val[3] = dispatch_pair.inst2.src2_value;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    for (genvar s = 0; s < MDQ_SLOTS; s++) begin : g_slot
      mdq_operand_slot #(
        .WAKE_PORTS(WAKE_PORTS)
      ) u_slot (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .load       (fire_d && tail_idx == PW'(e)),
        .active     (valid_q[e]),
        .load_tag   (dispatch_pair.tag[s]),
        .load_rdy   (dispatch_pair.rdy[s]),
        .load_value (disp_val[s]),
        .wakeup     (wakeup),
        .ready      (slot_rdy[e][s]),
        .value      (slot_val[e][s])
      );
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op1_q[i]   <= OP_NOP;
        op2_q[i]   <= OP_NOP;
        dest1_q[i] <= '0;
        dest2_q[i] <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      // Head and tail never alias when both fire: empty forbids
      // issue and full forbids dispatch.
      if (fire_d) begin
        tail_q            <= tail_q + 1'b1;
        valid_q[tail_idx] <= 1'b1;
        op1_q[tail_idx]   <= dispatch_pair.inst1.op;
        op2_q[tail_idx]   <= dispatch_pair.inst2.op;
        dest1_q[tail_idx] <= dispatch_pair.inst1.dest;
        dest2_q[tail_idx] <= dispatch_pair.inst2.dest;
      end
      if (fire_i) begin
        head_q            <= head_q + 1'b1;
        valid_q[head_idx] <= 1'b0;
      end
    end
  end

  always_comb begin
    head_rdy = valid_q[head_idx];
    for (int s = 0; s < MDQ_SLOTS; s++) begin
      head_rdy = head_rdy && slot_rdy[head_idx][s];
    end
  end

  assign issue_to_mul_div_valid = head_rdy;

  always_comb begin
    issue_inst1 = '0;
    issue_inst2 = '0;
    if (valid_q[head_idx]) begin
      issue_inst1.op         = op1_q[head_idx];
      issue_inst1.dest       = dest1_q[head_idx];
      issue_inst1.src1_value = slot_val[head_idx][0];
      issue_inst1.src2_value = slot_val[head_idx][1];
      issue_inst2.op         = op2_q[head_idx];
      issue_inst2.dest       = dest2_q[head_idx];
      issue_inst2.src1_value = slot_val[head_idx][2];
      issue_inst2.src2_value = slot_val[head_idx][3];
    end
  end

endmodule
